// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
// Holds the datapath width, the canonical NOP, the opcode constants used by
// decode, and the fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_OP_IMM = 7'd19;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_BRANCH = 7'd99;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StDrain
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           write a bubble regardless of stall
//   stall_i           hold current contents
//   load_i            capture pc_i/instr_i as a valid instruction
//   pc_i, instr_i     incoming instruction and its PC
//   valid_o, pc_o, instr_o  registered IF/ID contents (instr_o = NOP when invalid)
// Priority: flush > load > stall (hold) > bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned Xlen = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [Xlen-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [Xlen-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q;
    logic [Xlen-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (!stall_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory and feeds the IF/ID register that drives decode.
// Ports:
//   clk_i, rst_i                clock, asynchronous active-high reset
//   imem_req_o, imem_addr_o     registered request strobe and fetch address (= PC)
//   imem_rvalid_i, imem_rdata_i memory response
//   stall_i                     decode cannot accept; IF/ID holds
//   branch_taken_i, branch_target_i  redirect + flush (wins over stall)
//   if_id_valid_o, if_id_pc_o, if_id_instr_o  IF/ID contents
//   opcode_o                    if_id_instr_o[6:0]
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     Xlen    = XLEN,
    parameter logic [Xlen-1:0] ResetPc = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [Xlen-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [Xlen-1:0] branch_target_i,
    output logic            if_id_valid_o,
    output logic [Xlen-1:0] if_id_pc_o,
    output logic [31:0]     if_id_instr_o,
    output logic [6:0]      opcode_o
);

    fetch_state_t    state_q, state_d;
    logic [Xlen-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [Xlen-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;

    logic            ifid_load;
    logic [Xlen-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic [Xlen-1:0] target;
    logic            accept;

    assign target = branch_target_i & ~Xlen'(3);
    // IF/ID can take a new word if decode is moving or it only holds a bubble.
    assign accept = !stall_i || !if_id_valid_o;

    // req_q is the registered request strobe: it is set on the edge that enters
    // FETCH, so the FETCH cycle with req_q=1 is the request cycle. FETCH with
    // req_q=0 only occurs right after reset or after a redirect taken before
    // the request went out.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = 1'b0;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_load    = 1'b0;
        ifid_pc      = pc_q;
        ifid_instr   = imem_rdata_i;

        case (state_q)
            StFetch: begin
                if (branch_taken_i) begin
                    pc_d = target;
                    // A request already on the bus must have its response dropped.
                    if (req_q) state_d = StDrain;
                    else       req_d   = 1'b1;
                end else if (req_q) begin
                    state_d = StWait;
                end else begin
                    req_d = 1'b1;
                end
            end
            StWait: begin
                if (branch_taken_i) begin
                    pc_d = target;
                    if (imem_rvalid_i) begin
                        state_d = StFetch;
                        req_d   = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (imem_rvalid_i) begin
                    pc_d = pc_q + Xlen'(4);
                    if (accept) begin
                        ifid_load = 1'b1;
                        state_d   = StFetch;
                        req_d     = 1'b1;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata_i;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (branch_taken_i) begin
                    pc_d    = target;
                    state_d = StFetch;
                    req_d   = 1'b1;
                end else if (!stall_i) begin
                    ifid_load  = 1'b1;
                    ifid_pc    = skid_pc_q;
                    ifid_instr = skid_instr_q;
                    state_d    = StFetch;
                    req_d      = 1'b1;
                end
            end
            StDrain: begin
                if (branch_taken_i) pc_d = target;
                // If the stale response lands together with another redirect it
                // is still the one being drained, so leave DRAIN to avoid waiting
                // for a response that will never come.
                if (imem_rvalid_i) begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StFetch;
            pc_q         <= ResetPc;
            req_q        <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    if_id_reg #(
        .Xlen (Xlen)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (branch_taken_i),
        .stall_i (stall_i),
        .load_i  (ifid_load),
        .pc_i    (ifid_pc),
        .instr_i (ifid_instr),
        .valid_o (if_id_valid_o),
        .pc_o    (if_id_pc_o),
        .instr_o (if_id_instr_o)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign opcode_o    = if_id_instr_o[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model with random latency, a program-order
// reference model that predicts which fetched words must reach IF/ID, and a
// monitor that pops and compares each new IF/ID instruction.
module tb_fetch_unit;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic [6:0]  opcode_o;

    always #5 clk = ~clk;

    fetch_unit #(
        .Xlen    (32),
        .ResetPc (32'h0000_0000)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .if_id_valid_o   (if_id_valid_o),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .opcode_o        (opcode_o)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned pops   = 0;

    // Reference model state
    entry_t      exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] model_pc;
    bit          outst;
    bit          killed;
    int          lat;
    logic [31:0] out_addr;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    bit          fixed_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = OPC_LOAD;
            3'd1:    op = OPC_OP_IMM;
            3'd2:    op = OPC_STORE;
            3'd3:    op = OPC_OP;
            3'd4:    op = OPC_BRANCH;
            default: op = OPC_OP_IMM;
        endcase
        if (fixed_mode) return 32'h0050_0093;
        return {a[26:2] ^ 25'h1A5_A5A5, op};
    endfunction

    // One clock cycle: drive inputs at the falling edge, then advance the
    // reference model by what the coming rising edge will do.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt);
        bit resp;
        bit req;
        entry_t e;
        @(negedge clk);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_rvalid   = 1'b0;
        imem_rdata    = $urandom;
        resp          = 1'b0;
        req           = (imem_req_o === 1'b1);
        if (outst) begin
            if (lat <= 1) begin
                resp        = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(out_addr);
            end else begin
                lat--;
            end
        end
        if (req) begin
            chk("req_while_outstanding", 32'(outst), 32'd0);
            chk("imem_addr", imem_addr_o, model_pc);
            req_log.push_back(imem_addr_o);
        end
        if (resp) begin
            outst = 1'b0;
            if (!killed && !br) begin
                e.pc    = out_addr;
                e.instr = imem_rdata;
                exp_q.push_back(e);
                model_pc = out_addr + 32'd4;
            end
        end
        if (req) begin
            outst    = 1'b1;
            killed   = 1'b0;
            out_addr = imem_addr_o;
            lat      = int'($urandom_range(lat_max, lat_min));
        end
        if (br) begin
            model_pc = tgt & ~32'd3;
            killed   = 1'b1;
            exp_q.delete();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        outst    = 1'b0;
        killed   = 1'b0;
        model_pc = 32'h0000_0000;
    endtask

    // Monitor: compares IF/ID against the scoreboard just after each edge.
    initial begin
        entry_t e;
        entry_t last;
        bit     s_rst, s_stall, s_br, hold;
        bit     prev_valid, prev_req;
        prev_valid = 1'b0;
        prev_req   = 1'b0;
        last       = '0;
        forever begin
            @(posedge clk);
            s_rst   = rst;
            s_stall = stall;
            s_br    = branch_taken;
            #1;
            if (s_rst || rst) begin
                prev_valid = 1'b0;
                prev_req   = 1'b0;
                continue;
            end
            chk("req_back_to_back", 32'(imem_req_o & prev_req), 32'd0);
            if (s_br) chk("flush_bubble", 32'(if_id_valid_o), 32'd0);
            hold = s_stall && prev_valid && !s_br;
            if (if_id_valid_o !== 1'b1) begin
                if (hold) chk("hold_valid", 32'(if_id_valid_o), 32'd1);
                chk("bubble_instr", if_id_instr_o, NOP_INSTR);
                chk("bubble_opcode", 32'(opcode_o), 32'h13);
            end else if (hold) begin
                chk("hold_pc", if_id_pc_o, last.pc);
                chk("hold_instr", if_id_instr_o, last.instr);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h instr %h, expected none",
                         if_id_pc_o, if_id_instr_o);
            end else begin
                e = exp_q.pop_front();
                pops++;
                chk("ifid_pc", if_id_pc_o, e.pc);
                chk("ifid_instr", if_id_instr_o, e.instr);
                chk("ifid_opcode", 32'(opcode_o), 32'(e.instr[6:0]));
                last = e;
            end
            prev_valid = (if_id_valid_o === 1'b1);
            prev_req   = (imem_req_o === 1'b1);
        end
    end

    initial begin
        bit   v[12];
        bit   got;
        int   n;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        model_reset();

        // Reset values
        #3;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(if_id_valid_o), 32'd0);
        chk("rst_pc", if_id_pc_o, 32'd0);
        chk("rst_instr", if_id_instr_o, NOP_INSTR);
        chk("rst_opcode", 32'(opcode_o), 32'h13);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait stream of addi
        fixed_mode = 1'b1;
        lat_min    = 1;
        lat_max    = 1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'd0);
            v[i] = (if_id_valid_o === 1'b1);
            if (v[i]) chk("zw_opcode", 32'(opcode_o), 32'd19);
        end
        chk("zw_addr0", req_log[0], 32'h0);
        chk("zw_addr1", req_log[1], 32'h4);
        chk("zw_addr2", req_log[2], 32'h8);
        chk("zw_first_valid", 32'(v[2]), 32'd1);
        for (int i = 2; i < 11; i++) chk("zw_alternate", 32'(v[i] ^ v[i+1]), 32'd1);
        fixed_mode = 1'b0;

        // Branch while waiting on a slow response
        lat_min = 3;
        lat_max = 3;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 32'd0);
            got = (imem_req_o === 1'b1);
        end
        chk("br_found_req", 32'(got), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0103);
        n   = req_log.size();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 32'd0);
            got = (req_log.size() != n);
            if (!got) chk("drain_no_valid", 32'(if_id_valid_o), 32'd0);
        end
        chk("br_refetch_seen", 32'(got), 32'd1);
        chk("br_target_addr", req_log[req_log.size()-1], 32'h0000_0100);

        // Branch and stall together: flush wins
        lat_min = 1;
        lat_max = 2;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 32'd0);
            got = (if_id_valid_o === 1'b1);
        end
        chk("bs_found_valid", 32'(got), 32'd1);
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 32'd0);
        chk("bs_valid", 32'(if_id_valid_o), 32'd0);
        chk("bs_opcode", 32'(opcode_o), 32'h13);

        // Reset while a word sits in the skid buffer
        lat_min = 2;
        lat_max = 2;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 32'd0);
            got = (if_id_valid_o === 1'b1);
        end
        chk("hold_found_valid", 32'(got), 32'd1);
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 10 && outst; i++) step(1'b1, 1'b0, 32'd0);
        chk("hold_resp_done", 32'(outst), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req_o), 32'd0);
        chk("arst_addr", imem_addr_o, 32'h0);
        chk("arst_valid", 32'(if_id_valid_o), 32'd0);
        chk("arst_pc", if_id_pc_o, 32'd0);
        chk("arst_instr", if_id_instr_o, NOP_INSTR);
        chk("arst_opcode", 32'(opcode_o), 32'h13);
        model_reset();
        @(negedge clk);
        rst         = 1'b0;
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        n = req_log.size();
        step(1'b0, 1'b0, 32'd0);
        chk("arst_first_req", 32'(imem_req_o), 32'd1);
        chk("arst_restart_addr", req_log[n], 32'h0);

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom);
            step($urandom_range(99) < 30, $urandom_range(99) < 5, tgt);
        end

        // Let everything drain
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("enough_traffic", 32'(pops > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the main decoder. Holds the PC and issues one request at a time to instruction memory. Captures each returned word into the IF/ID register and presents `if_id_instr[6:0]` as the `opcode` that drives the decoder. Handles stalls from hazard logic and flushes on taken branches, and never lets a stale instruction reach decode.

## Interface
- `XLEN`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `imem_req` out 1: one-cycle request strobe to instruction memory.
- `imem_addr` out XLEN: fetch address. Valid only while `imem_req`=1. Equals the PC.
- `imem_rvalid` in 1: response strobe. Arrives at least 1 cycle after `imem_req`. At most one request is outstanding.
- `imem_rdata` in 32: instruction word. Valid only while `imem_rvalid`=1.
- `stall` in 1: decode cannot accept; IF/ID must hold its contents.
- `branch_taken` in 1: redirect and flush. Has priority over `stall`.
- `branch_target` in XLEN: new PC. Bits [1:0] are forced to 0 internally.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out XLEN: PC of the IF/ID instruction.
- `if_id_instr` out 32: instruction word, or NOP (32'h0000_0013) when invalid.
- `opcode` out 7: always equal to `if_id_instr[6:0]`.

## Operation
- The FSM has four states: FETCH, WAIT, HOLD, DRAIN.
- Reset is asynchronous.
  - Registers: pc=RESET_PC, state=FETCH, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=NOP, opcode=7'h13.
  - Skid buffer: cleared.
- FETCH:
  - Drive imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
  - If branch_taken is high in this cycle: do not issue; load pc=target and stay in FETCH.
- WAIT:
  - On imem_rvalid with IF/ID able to accept (stall=0 or if_id_valid=0): load IF/ID with {1, pc, rdata}, set pc+=4, go to FETCH.
  - On imem_rvalid with stall=1 and if_id_valid=1: store {pc, rdata} in the skid buffer, set pc+=4, go to HOLD.
- HOLD: on the first cycle with stall=0, move the skid buffer into IF/ID and go to FETCH.
- DRAIN: discard the next imem_rvalid, then go to FETCH. No request is issued while in DRAIN.
- IF/ID update rule:
  - stall=1: IF/ID holds.
  - stall=0 and no new word this cycle: load a bubble (valid=0, instr=NOP).
- branch_taken handling, in any state:
  - Load pc=target and write a bubble into IF/ID (even when stall=1).
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid in the same cycle: discard the word and go to FETCH.
  - HOLD: drop the skid buffer and go to FETCH.
  - DRAIN: stay in DRAIN, with the updated pc.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Request at cycle N and rvalid at N+k (k≥1): IF/ID shows the word after the edge ending cycle N+k.
- Zero-wait memory (k=1) gives 1 instruction per 2 cycles.
- imem_req is never high on two consecutive cycles.
- imem_req is never high in WAIT, HOLD or DRAIN.
- The first imem_req after rst falls is in the first cycle after deassertion.
- branch_taken takes effect at the next edge. The first fetch from the target is issued in the following cycle, or after the drain completes.
- All outputs are registered except opcode, which is a wire slice of if_id_instr.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`.
  - `NOP_INSTR` = 32'h0000_0013.
  - The opcode constants used by decode: LOAD=3, OP_IMM=19, STORE=35, OP=51, BRANCH=99.
  - `fetch_state_t` enum {FETCH, WAIT, HOLD, DRAIN}.
- One sub-module, `if_id_reg`: the pipeline register with stall/flush/bubble inputs and asynchronous reset. The FSM, PC and skid buffer stay in `fetch_unit`.

## Test plan
- Reset and zero-wait stream of 32'h00500093 (addi):
  - imem_addr sequence is 0, 4, 8.
  - if_id_valid=1 every other cycle; opcode=19.
- rvalid 3 cycles late: no second imem_req while in WAIT. IF/ID updates exactly once, with pc=0.
- stall=1 for 4 cycles while a response returns:
  - The word goes to the skid buffer and IF/ID holds.
  - After release, the next IF/ID pc = previous + 4, with no loss or duplication.
- branch_taken with target 32'h0000_0103 while in WAIT with no rvalid:
  - The next rvalid is discarded and the next imem_addr is 32'h0000_0100.
  - if_id_valid=0 in between.
- branch_taken and stall=1 in the same cycle: IF/ID becomes a bubble (opcode=7'h13, valid=0); the flush wins.
- rst asserted while in HOLD: all outputs return to their reset values asynchronously, and fetching restarts at RESET_PC.
